// File: rtl/ffe_ctrl_if.sv
// Coefficient configuration port and equalizer tap-write bus.
// master: control plane / equalizer side; slave: ffe_ctrl side.
interface ffe_ctrl_if #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 2
);
   logic                  coef_valid;
   logic [DATA_WIDTH-1:0] coef_data;
   logic                  coef_ready;
   logic                  coef_wr_en;
   logic [ADDR_WIDTH-1:0] coef_wr_addr;
   logic [DATA_WIDTH-1:0] coef_wr_data;

   modport master (
      output coef_valid,
      output coef_data,
      input  coef_ready,
      input  coef_wr_en,
      input  coef_wr_addr,
      input  coef_wr_data
   );

   modport slave (
      input  coef_valid,
      input  coef_data,
      output coef_ready,
      output coef_wr_en,
      output coef_wr_addr,
      output coef_wr_data
   );
endinterface

// File: rtl/ffe_ctrl.sv
// ffe_ctrl: sequences FFE coefficient load, then a decimated run.
// Ports: clk/rst, i_start/i_stop/i_num_samples command, coef_if
// (valid/ready coef port + tap write bus), o_load_signal,
// o_busy, o_done, o_out_count.
module ffe_ctrl #(
   parameter int DATA_WIDTH = 12,
   parameter int NUM_TAPS   = 4,
   parameter int DECIM      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic [CNT_WIDTH-1:0] i_num_samples,
   ffe_ctrl_if.slave            coef_if,
   output logic                 o_load_signal,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CNT_WIDTH-1:0] o_out_count
);
   localparam int AW = $clog2(NUM_TAPS);
   localparam int PW = $clog2(DECIM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_COEF,
      S_RUN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_WIDTH-1:0]  r_num;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [AW-1:0]         r_tap;
   logic [PW-1:0]         r_phase;
   logic                  r_wr_en;
   logic [AW-1:0]         r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  r_done;

   logic                  w_accept;
   logic                  w_last_tap;
   logic                  w_load;
   logic                  w_final;
   logic                  w_start_run;
   logic                  w_start_zero;
   logic [CNT_WIDTH-1:0]  w_cnt_inc;

   assign w_start_run  = (r_state == S_IDLE) && i_start &&
                         (i_num_samples != '0);
   assign w_start_zero = (r_state == S_IDLE) && i_start &&
                         (i_num_samples == '0);
   assign w_accept     = (r_state == S_LOAD_COEF) &&
                         coef_if.coef_valid;
   assign w_last_tap   = (r_tap == AW'(NUM_TAPS - 1));
   // Load strobe comes from registered state only.
   assign w_load       = (r_state == S_RUN) &&
                         (r_phase == PW'(DECIM - 1));
   assign w_cnt_inc    = r_cnt + CNT_WIDTH'(1);
   assign w_final      = w_load && (w_cnt_inc == r_num);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt        = r_state;
      o_busy             = 1'b0;
      o_load_signal      = 1'b0;
      coef_if.coef_ready = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_start_run) w_state_nxt = S_LOAD_COEF;
         end
         S_LOAD_COEF: begin
            o_busy             = 1'b1;
            coef_if.coef_ready = 1'b1;
            if (i_stop)
               w_state_nxt = S_IDLE;
            else if (w_accept && w_last_tap)
               w_state_nxt = S_RUN;
         end
         S_RUN: begin
            o_busy        = 1'b1;
            o_load_signal = w_load;
            if (i_stop)
               w_state_nxt = S_IDLE;
            else if (w_final)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_num     <= '0;
         r_cnt     <= '0;
         r_tap     <= '0;
         r_phase   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_done    <= 1'b0;
      end else begin
         r_wr_en <= w_accept;
         // A stop racing the final load still suppresses done.
         r_done  <= w_start_zero ||
                    ((r_state == S_RUN) && w_final && !i_stop);
         if (w_start_run) begin
            r_num <= i_num_samples;
            r_cnt <= '0;
            r_tap <= '0;
         end
         if (w_accept) begin
            r_wr_addr <= r_tap;
            r_wr_data <= coef_if.coef_data;
            r_tap     <= r_tap + AW'(1);
         end
         if (w_load) r_cnt <= w_cnt_inc;
         if ((r_state == S_RUN) && !w_load)
            r_phase <= r_phase + PW'(1);
         else
            r_phase <= '0;
      end
   end

   assign coef_if.coef_wr_en   = r_wr_en;
   assign coef_if.coef_wr_addr = r_wr_addr;
   assign coef_if.coef_wr_data = r_wr_data;
   assign o_done               = r_done;
   assign o_out_count          = r_cnt;

endmodule

// File: tb/tb_ffe_ctrl.sv
// Testbench for ffe_ctrl: directed sequences checked against a
// cycle-level behavioural model plus literal expectations.
module tb_ffe_ctrl;
   localparam int DW  = 12;
   localparam int NT  = 4;
   localparam int DEC = 4;
   localparam int CW  = 16;
   localparam int AW  = 2;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          stop  = 1'b0;
   logic [CW-1:0] num   = '0;
   logic          load;
   logic          busy;
   logic          done;
   logic [CW-1:0] out_count;

   ffe_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cif ();

   ffe_ctrl #(
      .DATA_WIDTH(DW),
      .NUM_TAPS  (NT),
      .DECIM     (DEC),
      .CNT_WIDTH (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (start),
      .i_stop       (stop),
      .i_num_samples(num),
      .coef_if      (cif),
      .o_load_signal(load),
      .o_busy       (busy),
      .o_done       (done),
      .o_out_count  (out_count)
   );

   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // Observation log filled at each falling edge.
   int wa_q[$];
   int wd_q[$];
   int ld_n, first_ld, last_ld, bad_gap;
   int done_n, rdy_n, hs_n, acc_last;

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      ld_n = 0; first_ld = 0; last_ld = 0; bad_gap = 0;
      done_n = 0; rdy_n = 0; hs_n = 0; acc_last = 0;
   endtask

   // Behavioural model: loading flag with next tap, running flag
   // with a countdown to the next load, and pending pulses.
   bit m_load = 0, m_run = 0, m_blk = 0, m_done = 0, m_wr = 0;
   int m_tap = 0, m_gap = 0, m_cnt = 0, m_num = 0;
   int m_wa = 0, m_wd = 0;

   initial begin
      bit n_wr, n_done, n_blk;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_load = 0; m_run = 0; m_blk = 0; m_done = 0;
            m_wr = 0; m_tap = 0; m_gap = 0; m_cnt = 0;
            m_num = 0; m_wa = 0; m_wd = 0;
         end
         chk("ready", cif.coef_ready, m_load);
         chk("busy", busy, m_load || m_run);
         chk("load", load, m_run && (m_gap == 0));
         chk("done", done, m_done);
         chk("out_count", out_count, m_cnt);
         chk("wr_en", cif.coef_wr_en, m_wr);
         if (m_wr) begin
            chk("wr_addr", cif.coef_wr_addr, m_wa);
            chk("wr_data", cif.coef_wr_data, m_wd);
         end
         if (cif.coef_wr_en) begin
            wa_q.push_back(int'(cif.coef_wr_addr));
            wd_q.push_back(int'(cif.coef_wr_data));
         end
         if (load) begin
            if (ld_n == 0) first_ld = cyc_n;
            else if (cyc_n - last_ld != DEC) bad_gap++;
            last_ld = cyc_n;
            ld_n++;
         end
         if (done) done_n++;
         if (cif.coef_ready) rdy_n++;
         if (cif.coef_ready && cif.coef_valid) begin
            hs_n++;
            acc_last = cyc_n;
         end
         if (!rst) begin
            n_wr = 0; n_done = 0; n_blk = 0;
            if (m_load) begin
               if (cif.coef_valid) begin
                  n_wr = 1;
                  m_wa = m_tap;
                  m_wd = int'(cif.coef_data);
                  m_tap++;
                  if (m_tap == NT) begin
                     m_load = 0; m_run = 1; m_gap = DEC - 1;
                  end
               end
               if (stop) begin m_load = 0; m_run = 0; end
            end else if (m_run) begin
               if (m_gap == 0) begin
                  m_cnt++;
                  m_gap = DEC - 1;
                  if (m_cnt == m_num) begin
                     m_run = 0;
                     if (!stop) begin n_done = 1; n_blk = 1; end
                  end
               end else begin
                  m_gap--;
               end
               if (stop) m_run = 0;
            end else if (!m_blk && start) begin
               if (num == 0) n_done = 1;
               else begin
                  m_load = 1; m_tap = 0; m_cnt = 0; m_num = int'(num);
               end
            end
            m_wr = n_wr; m_done = n_done; m_blk = n_blk;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int n);
      num = CW'(n);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic load_coefs(input logic [DW-1:0] c0, c1, c2, c3,
                             input bit tog);
      logic [DW-1:0] cs [4];
      int idx;
      bit ph, hs;
      cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
      idx = 0;
      ph = 1'b1;
      for (int g = 0; g < 60 && idx < NT; g++) begin
         cif.coef_valid = tog ? ph : 1'b1;
         cif.coef_data  = cs[idx];
         ph = !ph;
         hs = cif.coef_valid && cif.coef_ready;
         step();
         if (hs) idx++;
      end
      cif.coef_valid = 1'b0;
      chk("coef_load_bound", idx, NT);
   endtask

   task automatic wait_done(input int max);
      bit ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         step();
         if (done_n > 0) begin ok = 1; break; end
      end
      chk("done_bound", ok, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      cif.coef_valid = 1'b0;
      cif.coef_data  = '0;
      clear_log();

      // Reset state
      step(); step();
      chk("rst_load", load, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", out_count, 0);
      chk("rst_ready", cif.coef_ready, 0);
      chk("rst_wr", cif.coef_wr_en, 0);
      rst = 1'b0;
      clear_log();
      for (int i = 0; i < 10; i++) step();
      chk("idle_ld", ld_n, 0);
      chk("idle_wr", wa_q.size(), 0);
      chk("idle_done", done_n, 0);
      chk("idle_rdy", rdy_n, 0);

      // Full run, 250 samples, valid held high
      clear_log();
      start_run(250);
      load_coefs(12'h7FF, 12'h001, 12'hF00, 12'h800, 1'b0);
      wait_done(1100);
      step(); step();
      chk("t2_wr_n", wa_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("t2_wa", wa_q[i], i);
      chk("t2_wd0", wd_q[0], 32'h7FF);
      chk("t2_wd1", wd_q[1], 32'h001);
      chk("t2_wd2", wd_q[2], 32'hF00);
      chk("t2_wd3", wd_q[3], 32'h800);
      chk("t2_ld_n", ld_n, 250);
      chk("t2_first", first_ld - acc_last, DEC);
      chk("t2_gap", bad_gap, 0);
      chk("t2_done_n", done_n, 1);
      chk("t2_cnt", out_count, 250);

      // Toggling coef_valid
      clear_log();
      start_run(2);
      load_coefs(12'h123, 12'h456, 12'h789, 12'hABC, 1'b1);
      wait_done(40);
      chk("t3_wr_n", wa_q.size(), 4);
      chk("t3_hs_n", hs_n, 4);
      for (int i = 0; i < 4; i++) chk("t3_wa", wa_q[i], i);
      chk("t3_wd3", wd_q[3], 32'hABC);
      chk("t3_ld_n", ld_n, 2);

      // Stop on the cycle of the 5th load
      clear_log();
      start_run(10);
      load_coefs(12'h010, 12'h020, 12'h030, 12'h040, 1'b0);
      ok = 0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (load) begin
            n++;
            if (n == 5) begin ok = 1; break; end
         end
         step();
      end
      chk("t4_reach5", ok, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_cnt", out_count, 5);
      for (int i = 0; i < 8; i++) step();
      chk("t4_done_n", done_n, 0);
      chk("t4_ld_n", ld_n, 5);
      chk("t4_cnt_hold", out_count, 5);

      // Zero-sample start
      clear_log();
      start_run(0);
      chk("t5_done", done, 1);
      for (int i = 0; i < 6; i++) step();
      chk("t5_rdy", rdy_n, 0);
      chk("t5_ld", ld_n, 0);
      chk("t5_done_n", done_n, 1);

      // Start while busy is ignored, count not re-latched
      clear_log();
      start_run(3);
      start_run(7);
      num = '0;
      load_coefs(12'h001, 12'h002, 12'h003, 12'h004, 1'b0);
      wait_done(60);
      step(); step();
      chk("t5b_ld", ld_n, 3);
      chk("t5b_cnt", out_count, 3);
      chk("t5b_wr_n", wa_q.size(), 4);

      // Async reset on a load cycle
      clear_log();
      start_run(20);
      load_coefs(12'h111, 12'h222, 12'h333, 12'h444, 1'b0);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (load) begin ok = 1; break; end
         step();
      end
      chk("t6_seen_load", ok, 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_load", load, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cnt", out_count, 0);
      chk("t6_wr", cif.coef_wr_en, 0);
      chk("t6_ready", cif.coef_ready, 0);
      step(); step();
      rst = 1'b0;
      clear_log();
      for (int i = 0; i < 8; i++) step();
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_ld", ld_n, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
